btn_event_tx: RTL



---
 rtl/btn_event_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 35 +++
 rtl/btn_event_tx.sv | 80 ++++++++
 3 files changed

// File: rtl/btn_event_pkg.sv
// btn_event_pkg: shared constants for the button-event transmitter.
//   NUM_BTN   number of board push-buttons
//   BTN_*     button index into btn_raw / btn_level
//   EV_*      event codes presented on ev_code (EV_NONE when the queue is empty)
//   btn_code  maps a button index to its event code
package btn_event_pkg;
  localparam int NUM_BTN = 5;
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;
  localparam int EV_W = 3;
  localparam logic [EV_W-1:0] EV_NONE = 3'd0;
  localparam logic [EV_W-1:0] EV_C = 3'd1;
  localparam logic [EV_W-1:0] EV_U = 3'd2;
  localparam logic [EV_W-1:0] EV_L = 3'd3;
  localparam logic [EV_W-1:0] EV_R = 3'd4;
  localparam logic [EV_W-1:0] EV_D = 3'd5;
  function automatic logic [EV_W-1:0] btn_code(input int idx);
    return EV_W'(idx + 1);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus debounce counter for one button.
//   clk, rst_n  system clock, async active-low reset
//   raw         asynchronous pin
//   level       debounced level
//   rise        one-cycle pulse on the edge where level goes 0->1
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic s1, s2, stable, hit;
  logic [CW-1:0] cnt;
  // D-th consecutive mismatching sample accepts the new level
  assign hit = (s2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign level = stable;
  assign rise = hit && !stable;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      stable <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      cnt <= (s2 == stable || hit) ? '0 : cnt + 1'b1;
      if (hit) stable <= ~stable;
    end
  end
endmodule

// File: rtl/btn_event_tx.sv
// btn_event_tx: debounced button presses queued and streamed as 3-bit event codes.
//   clk, rst_n  system clock, async active-low reset
//   btn_raw     raw button pins (0=C 1=U 2=L 3=R 4=D)
//   ev_ready    consumer takes the head event
//   ovf_clr     clears overflow
//   ev_valid    queue non-empty
//   ev_code     head event code, EV_NONE when empty
//   btn_level   debounced levels
//   overflow    sticky dropped-press flag
module btn_event_tx
  import btn_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic ev_ready,
  input  logic ovf_clr,
  output logic ev_valid,
  output logic [EV_W-1:0] ev_code,
  output logic [NUM_BTN-1:0] btn_level,
  output logic overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [NUM_BTN-1:0] rise, pending, sel, clr, drop;
  logic [EV_W-1:0] push_code;
  logic [EV_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic full, push, pop;
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .rst_n(rst_n),
      .raw(btn_raw[i]),
      .level(btn_level[i]),
      .rise(rise[i])
    );
  end
  // scan high to low so the lowest-index pending button wins
  always_comb begin
    push_code = EV_NONE;
    sel = '0;
    for (int k = NUM_BTN - 1; k >= 0; k--) begin
      if (pending[k]) begin
        push_code = btn_code(k);
        sel = NUM_BTN'(1) << k;
      end
    end
  end
  // fullness uses the registered count, so a same-cycle pop never frees a slot
  assign full = count == (AW + 1)'(FIFO_DEPTH);
  assign push = |pending && !full;
  assign pop = ev_valid && ev_ready;
  assign clr = push ? sel : '0;
  // a press landing on a bit that is being pushed this cycle is kept, not dropped
  assign drop = rise & pending & ~clr;
  assign ev_valid = count != '0;
  assign ev_code = ev_valid ? mem[rd_ptr] : EV_NONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | rise;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      overflow <= |drop ? 1'b1 : ovf_clr ? 1'b0 : overflow;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_code;
  end
endmodule
